// File: rtl/traffic_ctrl_multi.sv
// traffic_ctrl_multi: multi-approach traffic light controller.
//
// Serves N_DIR approaches in turn through green, yellow and all-red
// clearance. Phase durations are in seconds, timed from a 1 s tick
// derived from clk by a free-running prescaler. A latched pedestrian
// request inserts an all-red walk phase. Night mode blinks all yellows.
// enable low freezes the prescaler, the phase timer and the state.
//
// Optional build macro: TRF_REDAMBER_EN adds a red+yellow phase before
// every green (REDAMBER_S ticks long).
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   enable     1 = timing advances, 0 = timing and state hold
//   night_mode request blinking-yellow operation
//   ped_req    pedestrian button, level sampled every cycle
//   red        red lamp per direction
//   yellow     yellow lamp per direction
//   green      green lamp per direction
//   ped_walk   pedestrian walk lamp
//   active_dir direction currently served
//
// state       | meaning
// ------------+------------------------------------------------
// S_ALL_RED   | clearance, every approach red
// S_GREEN     | active_dir green, others red
// S_YELLOW    | active_dir yellow, others red
// S_WALK      | every approach red, pedestrian walk lit
// S_NIGHT     | all yellows blink 1 s on / 1 s off
// S_REDAMBER  | red+yellow on the next direction (macro only)
module traffic_ctrl_multi #(
  parameter int CLK_HZ     = 10000000,
  parameter int N_DIR      = 2,
  parameter int GREEN_S    = 5,
  parameter int YELLOW_S   = 2,
  parameter int ALLRED_S   = 1,
  parameter int WALK_S     = 4,
  parameter int REDAMBER_S = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     night_mode,
  input  logic                     ped_req,
  output logic [N_DIR-1:0]         red,
  output logic [N_DIR-1:0]         yellow,
  output logic [N_DIR-1:0]         green,
  output logic                     ped_walk,
  output logic [$clog2(N_DIR)-1:0] active_dir
);

  localparam int PW = $clog2(CLK_HZ);
  localparam int DW = $clog2(N_DIR);
  // Longest phase in ticks; night uses a two-tick (on/off) period.
  localparam int M1    = (GREEN_S > YELLOW_S) ? GREEN_S : YELLOW_S;
  localparam int M2    = (M1 > ALLRED_S) ? M1 : ALLRED_S;
  localparam int M3    = (M2 > WALK_S) ? M2 : WALK_S;
  localparam int M4    = (M3 > REDAMBER_S) ? M3 : REDAMBER_S;
  localparam int MAX_D = (M4 > 2) ? M4 : 2;
  localparam int TW    = $clog2(MAX_D);

  localparam logic [PW-1:0]    PRE_LAST = PW'(CLK_HZ - 1);
  localparam logic [N_DIR-1:0] ONE      = N_DIR'(1);

  typedef enum logic [2:0] {
    S_ALL_RED,
    S_GREEN,
    S_YELLOW,
    S_WALK,
    S_NIGHT
`ifdef TRF_REDAMBER_EN
    , S_REDAMBER
`endif
  } state_t;

  state_t           state, state_nx;
  logic [PW-1:0]    pre;
  logic             tick;
  logic [TW-1:0]    timer, timer_nx, last;
  logic [DW-1:0]    dir_nx, dir_inc;
  logic             restart, restart_nx;
  logic             ped_pending, ped_pending_nx;
  logic             after_walk, after_walk_nx;
  logic [N_DIR-1:0] sel, red_nx, yellow_nx, green_nx;
  logic             walk_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre <= '0;
    end else if (enable) begin
      pre <= (pre == PRE_LAST) ? '0 : pre + PW'(1);
    end
  end

  assign tick    = enable && (pre == PRE_LAST);
  assign dir_inc = (active_dir == DW'(N_DIR - 1)) ? '0 : active_dir + DW'(1);

  always_comb begin
    last = '0;
    case (state)
      S_ALL_RED:  last = TW'(ALLRED_S - 1);
      S_GREEN:    last = TW'(GREEN_S - 1);
      S_YELLOW:   last = TW'(YELLOW_S - 1);
      S_WALK:     last = TW'(WALK_S - 1);
      S_NIGHT:    last = TW'(1);
`ifdef TRF_REDAMBER_EN
      S_REDAMBER: last = TW'(REDAMBER_S - 1);
`endif
      default:    last = '0;
    endcase
  end

  always_comb begin
    state_nx      = state;
    timer_nx      = timer;
    dir_nx        = active_dir;
    restart_nx    = restart;
    after_walk_nx = after_walk;
    if (tick) begin
      if (timer == last) begin
        timer_nx = '0;
        case (state)
          S_ALL_RED: begin
            if (night_mode) begin
              state_nx = S_NIGHT;
            end else if (ped_pending && !after_walk) begin
              state_nx = S_WALK;
            end else begin
              // restart forces direction 0 after reset or night mode
              dir_nx        = restart ? '0 : dir_inc;
              restart_nx    = 1'b0;
              after_walk_nx = 1'b0;
`ifdef TRF_REDAMBER_EN
              state_nx      = S_REDAMBER;
`else
              state_nx      = S_GREEN;
`endif
            end
          end
          S_GREEN:  state_nx = S_YELLOW;
          S_YELLOW: state_nx = S_ALL_RED;
          S_WALK:   state_nx = S_ALL_RED;
          S_NIGHT: begin
            // only reached at the end of an off second
            if (!night_mode) begin
              state_nx   = S_ALL_RED;
              restart_nx = 1'b1;
              dir_nx     = '0;
            end
          end
`ifdef TRF_REDAMBER_EN
          S_REDAMBER: state_nx = S_GREEN;
`endif
          default: state_nx = S_ALL_RED;
        endcase
      end else begin
        timer_nx = timer + TW'(1);
      end
    end

    // Walk entry wins over a same-cycle button press.
    ped_pending_nx = ped_pending;
    if (state_nx == S_WALK && state != S_WALK) begin
      ped_pending_nx = 1'b0;
      after_walk_nx  = 1'b1;
    end else if (ped_req && state != S_WALK) begin
      ped_pending_nx = 1'b1;
    end

    // Lamps are decoded from the next state so they register with it.
    sel       = ONE << dir_nx;
    red_nx    = '1;
    yellow_nx = '0;
    green_nx  = '0;
    walk_nx   = 1'b0;
    case (state_nx)
      S_GREEN: begin
        green_nx = sel;
        red_nx   = ~sel;
      end
      S_YELLOW: begin
        yellow_nx = sel;
        red_nx    = ~sel;
      end
      S_WALK:   walk_nx = 1'b1;
      S_NIGHT: begin
        red_nx    = '0;
        yellow_nx = (timer_nx == '0) ? '1 : '0;
      end
`ifdef TRF_REDAMBER_EN
      S_REDAMBER: yellow_nx = sel;
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_ALL_RED;
      timer       <= '0;
      active_dir  <= '0;
      restart     <= 1'b1;
      ped_pending <= 1'b0;
      after_walk  <= 1'b0;
      red         <= '1;
      yellow      <= '0;
      green       <= '0;
      ped_walk    <= 1'b0;
    end else begin
      state       <= state_nx;
      timer       <= timer_nx;
      active_dir  <= dir_nx;
      restart     <= restart_nx;
      ped_pending <= ped_pending_nx;
      after_walk  <= after_walk_nx;
      red         <= red_nx;
      yellow      <= yellow_nx;
      green       <= green_nx;
      ped_walk    <= walk_nx;
    end
  end

endmodule
